// File: rtl/issue_stage_pkg.sv
// register_file_params: shared widths and the issue FSM state type.
//   REGISTER_DESCRIPTOR_WIDTH - width of a register descriptor (register index)
//   OPERAND_WIDTH             - width of a register value
//   REGISTER_SIZE             - number of architectural registers
//   OPCODE_WIDTH              - width of an operation code
// Register 0 is the hard-wired zero register: it reads as 0 and is never
// reserved.
package register_file_params;

  localparam int REGISTER_DESCRIPTOR_WIDTH = 4;
  localparam int OPERAND_WIDTH             = 16;
  localparam int REGISTER_SIZE             = 1 << REGISTER_DESCRIPTOR_WIDTH;
  localparam int OPCODE_WIDTH              = 4;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    READ       = 2'd1,
    DEST_CHECK = 2'd2,
    ISSUE      = 2'd3
  } issue_state_t;

endpackage

// File: rtl/issue_stage.sv
// issue_stage: single-slot in-order issue stage with scoreboard interlock.
//
// An accepted instruction reads both source registers, waiting while the
// register file reports one of them reserved (RAW). If it writes a non-zero
// destination, the stage then waits until that destination is free (WAW).
// After that it offers the instruction to the execution unit. On the
// handshake, the destination is reserved through the shared register-file
// write port. Execution-unit write-backs pass straight through to the same
// port with zero latency. A write-back always takes priority over a
// reservation.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   instr_valid_input / instr_ready_output
//                                 decoded instruction handshake
//   opcode_input, src0_input, src1_input, dest_input, dest_write_input
//                                 decoded instruction fields
//   register_operand{0,1}_output  register-file read descriptors
//   register_operand{0,1}_input   register-file read data
//   reserved_input                a read descriptor is currently reserved
//   write_reserve_output, write_back_output,
//   write_back_register_output, result_output
//                                 shared register-file write port
//   wb_valid_input, wb_register_input, wb_result_input
//                                 execution-unit write-back (cannot stall)
//   issue_valid_output / issue_ready_input, issue_*_output
//                                 instruction to the execution unit
//
// State | meaning
// IDLE       | ready for a new instruction
// READ       | sources on read ports, wait for them to be unreserved
// DEST_CHECK | destination on read ports, wait for it to be unreserved
// ISSUE      | offering the instruction to the execution unit
module issue_stage
  import register_file_params::*;
(
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 instr_valid_input,
  output logic                                 instr_ready_output,
  input  logic [OPCODE_WIDTH-1:0]              opcode_input,
  input  logic [REGISTER_DESCRIPTOR_WIDTH-1:0] src0_input,
  input  logic [REGISTER_DESCRIPTOR_WIDTH-1:0] src1_input,
  input  logic [REGISTER_DESCRIPTOR_WIDTH-1:0] dest_input,
  input  logic                                 dest_write_input,
  output logic [REGISTER_DESCRIPTOR_WIDTH-1:0] register_operand0_output,
  output logic [REGISTER_DESCRIPTOR_WIDTH-1:0] register_operand1_output,
  input  logic [OPERAND_WIDTH-1:0]             register_operand0_input,
  input  logic [OPERAND_WIDTH-1:0]             register_operand1_input,
  input  logic                                 reserved_input,
  output logic                                 write_reserve_output,
  output logic                                 write_back_output,
  output logic [REGISTER_DESCRIPTOR_WIDTH-1:0] write_back_register_output,
  output logic [OPERAND_WIDTH-1:0]             result_output,
  input  logic                                 wb_valid_input,
  input  logic [REGISTER_DESCRIPTOR_WIDTH-1:0] wb_register_input,
  input  logic [OPERAND_WIDTH-1:0]             wb_result_input,
  output logic                                 issue_valid_output,
  input  logic                                 issue_ready_input,
  output logic [OPCODE_WIDTH-1:0]              issue_opcode_output,
  output logic [OPERAND_WIDTH-1:0]             issue_operand0_output,
  output logic [OPERAND_WIDTH-1:0]             issue_operand1_output,
  output logic [REGISTER_DESCRIPTOR_WIDTH-1:0] issue_dest_output
);

  issue_state_t                         state, state_next;
  logic [OPCODE_WIDTH-1:0]              lat_opcode;
  logic [REGISTER_DESCRIPTOR_WIDTH-1:0] lat_src0, lat_src1, lat_dest;
  logic                                 lat_dest_write;
  logic [OPERAND_WIDTH-1:0]             operand0, operand1;
  logic                                 needs_reserve;

  assign needs_reserve = lat_dest_write && (lat_dest != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      lat_opcode     <= '0;
      lat_src0       <= '0;
      lat_src1       <= '0;
      lat_dest       <= '0;
      lat_dest_write <= 1'b0;
      operand0       <= '0;
      operand1       <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && instr_valid_input) begin
        lat_opcode     <= opcode_input;
        lat_src0       <= src0_input;
        lat_src1       <= src1_input;
        lat_dest       <= dest_input;
        lat_dest_write <= dest_write_input;
      end
      if (state == READ && !reserved_input) begin
        operand0 <= (lat_src0 == '0) ? '0 : register_operand0_input;
        operand1 <= (lat_src1 == '0) ? '0 : register_operand1_input;
      end
    end
  end

  always_comb begin
    state_next               = state;
    register_operand0_output = lat_src0;
    register_operand1_output = lat_src1;
    issue_valid_output       = 1'b0;
    write_reserve_output     = 1'b0;
    case (state)
      IDLE: begin
        if (instr_valid_input) state_next = READ;
      end
      READ: begin
        if (!reserved_input) state_next = needs_reserve ? DEST_CHECK : ISSUE;
      end
      DEST_CHECK: begin
        register_operand0_output = lat_dest;
        register_operand1_output = lat_dest;
        if (!reserved_input) state_next = ISSUE;
      end
      ISSUE: begin
        // A reservation needs the shared write port, so hold off the issue
        // while a write-back is using that port.
        issue_valid_output = !(needs_reserve && wb_valid_input);
        if (issue_valid_output && issue_ready_input) begin
          write_reserve_output = needs_reserve;
          state_next           = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign instr_ready_output         = (state == IDLE);
  assign write_back_output          = wb_valid_input;
  assign result_output              = wb_result_input;
  assign write_back_register_output = wb_valid_input ? wb_register_input : lat_dest;

  assign issue_opcode_output   = lat_opcode;
  assign issue_operand0_output = operand0;
  assign issue_operand1_output = operand1;
  assign issue_dest_output     = lat_dest;

endmodule

// File: tb/tb_issue_stage.sv
// Testbench for issue_stage. The bench provides a register file with
// reservation bits and an execution unit that writes results back after a
// delay. The reference model is an in-order architectural register array.
// Expected operands come from program order, and an expected issue record is
// queued at every accept. A monitor pops that queue at every issue handshake.
module tb_issue_stage;
  import register_file_params::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid_input = 1'b0;
  logic        instr_ready_output;
  logic [3:0]  opcode_input = '0, src0_input = '0, src1_input = '0, dest_input = '0;
  logic        dest_write_input = 1'b0;
  logic [3:0]  register_operand0_output, register_operand1_output;
  logic [15:0] register_operand0_input, register_operand1_input;
  logic        reserved_input;
  logic        write_reserve_output, write_back_output;
  logic [3:0]  write_back_register_output;
  logic [15:0] result_output;
  logic        wb_valid_input = 1'b0;
  logic [3:0]  wb_register_input = '0;
  logic [15:0] wb_result_input = '0;
  logic        issue_valid_output;
  logic        issue_ready_input = 1'b1;
  logic [3:0]  issue_opcode_output, issue_dest_output;
  logic [15:0] issue_operand0_output, issue_operand1_output;

  issue_stage dut (
    .clk(clk), .rst(rst),
    .instr_valid_input(instr_valid_input), .instr_ready_output(instr_ready_output),
    .opcode_input(opcode_input), .src0_input(src0_input), .src1_input(src1_input),
    .dest_input(dest_input), .dest_write_input(dest_write_input),
    .register_operand0_output(register_operand0_output),
    .register_operand1_output(register_operand1_output),
    .register_operand0_input(register_operand0_input),
    .register_operand1_input(register_operand1_input),
    .reserved_input(reserved_input),
    .write_reserve_output(write_reserve_output), .write_back_output(write_back_output),
    .write_back_register_output(write_back_register_output), .result_output(result_output),
    .wb_valid_input(wb_valid_input), .wb_register_input(wb_register_input),
    .wb_result_input(wb_result_input),
    .issue_valid_output(issue_valid_output), .issue_ready_input(issue_ready_input),
    .issue_opcode_output(issue_opcode_output), .issue_operand0_output(issue_operand0_output),
    .issue_operand1_output(issue_operand1_output), .issue_dest_output(issue_dest_output)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  opc;
    logic [15:0] op0;
    logic [15:0] op1;
    logic [3:0]  dest;
    logic        rsv;
    int          lat;
    int          acc;
  } exp_t;

  typedef struct {
    logic [3:0]  r;
    logic [15:0] v;
  } wb_t;

  exp_t        sb[$];
  wb_t         pend[$];
  logic [15:0] regs [REGISTER_SIZE];
  bit          resv [REGISTER_SIZE];
  logic [15:0] arch [REGISTER_SIZE];
  logic [15:0] arch_save [REGISTER_SIZE];
  int          nchk = 0, nerr = 0;
  int          cyc = 0;
  int          ready_mode = 0;
  int          wb_delay_rand = 0;
  int          wb_wait = 0;

  assign register_operand0_input = regs[register_operand0_output];
  assign register_operand1_input = regs[register_operand1_output];
  assign reserved_input = resv[register_operand0_output] | resv[register_operand1_output];

  function automatic logic [15:0] exec_fn(logic [3:0] opc, logic [15:0] a, logic [15:0] b);
    logic [15:0] o;
    o = {12'b0, opc};
    return a ^ (b + o);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  initial forever begin
    @(posedge clk); #1;
    case (ready_mode)
      0: issue_ready_input = 1'b1;
      1: issue_ready_input = ($urandom_range(0, 99) < 70);
      default: issue_ready_input = 1'b0;
    endcase
  end

  // Register file and execution unit environment.
  initial begin
    logic s_rsv, s_wb, s_fire;
    logic [3:0] s_wreg, s_dest, s_opc;
    logic [15:0] s_res, s_op0, s_op1;
    wb_t w;
    forever begin
      @(negedge clk);
      s_rsv  = write_reserve_output;
      s_wb   = write_back_output;
      s_wreg = write_back_register_output;
      s_res  = result_output;
      s_fire = issue_valid_output && issue_ready_input;
      s_dest = issue_dest_output;
      s_opc  = issue_opcode_output;
      s_op0  = issue_operand0_output;
      s_op1  = issue_operand1_output;
      @(posedge clk); #1;
      if (s_wb) begin
        regs[s_wreg] = s_res;
        resv[s_wreg] = 1'b0;
      end
      if (s_rsv) resv[s_wreg] = 1'b1;
      if (s_fire && s_rsv) begin
        w.r = s_dest;
        w.v = exec_fn(s_opc, s_op0, s_op1);
        pend.push_back(w);
      end
      if (pend.size() > 0 && wb_wait == 0) begin
        w = pend.pop_front();
        wb_valid_input    = 1'b1;
        wb_register_input = w.r;
        wb_result_input   = w.v;
        wb_wait = (wb_delay_rand != 0) ? int'($urandom_range(0, 4)) : 3;
      end else begin
        wb_valid_input    = 1'b0;
        wb_register_input = 4'($urandom);
        wb_result_input   = 16'($urandom);
        if (wb_wait > 0) wb_wait--;
      end
    end
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (wb_valid_input) begin
        nchk++;
        if (write_back_output !== 1'b1 || result_output !== wb_result_input ||
            write_back_register_output !== wb_register_input) begin
          nerr++;
          $display("FAIL wb_passthru: got wb=%b reg=%0d res=%h, need wb=1 reg=%0d res=%h",
                   write_back_output, write_back_register_output, result_output,
                   wb_register_input, wb_result_input);
        end
        nchk++;
        if (write_reserve_output !== 1'b0) begin
          nerr++;
          $display("FAIL reserve_vs_wb: write_reserve=%b with wb_valid=1, need 0", write_reserve_output);
        end
      end else begin
        nchk++;
        if (write_back_output !== 1'b0) begin
          nerr++;
          $display("FAIL wb_idle: write_back=%b, need 0", write_back_output);
        end
      end
      if (write_reserve_output === 1'b1) begin
        nchk++;
        if (!(issue_valid_output && issue_ready_input)) begin
          nerr++;
          $display("FAIL reserve_no_handshake: write_reserve=1 without issue handshake");
        end
      end
      if (issue_valid_output && sb.size() > 0 && sb[0].rsv) begin
        nchk++;
        if (wb_valid_input) begin
          nerr++;
          $display("FAIL collision: issue_valid=1 with wb_valid=1 for reserving instr, need issue_valid=0");
        end
      end
      if (issue_valid_output && issue_ready_input) begin
        nchk++;
        if (sb.size() == 0) begin
          nerr++;
          $display("FAIL unexpected_issue: issue handshake with no instruction outstanding");
        end else begin
          e = sb.pop_front();
          if (issue_opcode_output !== e.opc || issue_operand0_output !== e.op0 ||
              issue_operand1_output !== e.op1 || issue_dest_output !== e.dest) begin
            nerr++;
            $display("FAIL issue_payload: got opc=%0d op0=%h op1=%h dest=%0d, need opc=%0d op0=%h op1=%h dest=%0d",
                     issue_opcode_output, issue_operand0_output, issue_operand1_output,
                     issue_dest_output, e.opc, e.op0, e.op1, e.dest);
          end
          nchk++;
          if (write_reserve_output !== e.rsv ||
              (e.rsv && write_back_register_output !== e.dest)) begin
            nerr++;
            $display("FAIL issue_reserve: got reserve=%b reg=%0d, need reserve=%b reg=%0d",
                     write_reserve_output, write_back_register_output, e.rsv, e.dest);
          end
          if (e.lat >= 0) begin
            nchk++;
            if (cyc - e.acc != e.lat) begin
              nerr++;
              $display("FAIL issue_latency: got %0d cycles, need %0d", cyc - e.acc, e.lat);
            end
          end
        end
      end
    end
  end

  task automatic send(input logic [3:0] opc, input logic [3:0] s0, input logic [3:0] s1,
                      input logic [3:0] d, input logic dw, input int lat);
    exp_t e;
    bit acc = 0;
    @(posedge clk); #1;
    instr_valid_input = 1'b1;
    opcode_input = opc; src0_input = s0; src1_input = s1;
    dest_input = d; dest_write_input = dw;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (instr_ready_output) begin
        acc = 1;
        break;
      end
    end
    if (!acc) begin
      nchk++; nerr++;
      $display("FAIL accept_timeout: instr_ready=0 for 300 cycles, need 1");
    end else begin
      e.opc  = opc;
      e.op0  = (s0 == 4'd0) ? 16'h0 : arch[s0];
      e.op1  = (s1 == 4'd0) ? 16'h0 : arch[s1];
      e.dest = d;
      e.rsv  = dw && (d != 4'd0);
      e.lat  = lat;
      e.acc  = cyc;
      if (e.rsv) arch[d] = exec_fn(opc, e.op0, e.op1);
      sb.push_back(e);
    end
    @(posedge clk); #1;
    instr_valid_input = 1'b0;
  endtask

  task automatic drain();
    bit done = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && pend.size() == 0 && !wb_valid_input) begin
        done = 1;
        break;
      end
    end
    nchk++;
    if (!done) begin
      nerr++;
      $display("FAIL drain_timeout: %0d instructions still outstanding, need 0", sb.size());
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", nerr + 1, nchk + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    for (int i = 0; i < REGISTER_SIZE; i++) begin
      regs[i] = 16'($urandom);
      resv[i] = 1'b0;
    end
    regs[0] = 16'hDEAD;
    regs[2] = 16'd5;
    regs[3] = 16'd7;
    for (int i = 0; i < REGISTER_SIZE; i++) arch[i] = regs[i];
    arch[0] = 16'h0;

    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    @(negedge clk);
    nchk++;
    if (instr_ready_output !== 1'b1 || issue_valid_output !== 1'b0 || write_reserve_output !== 1'b0) begin
      nerr++;
      $display("FAIL reset_state: ready=%b issue_valid=%b reserve=%b, need 1/0/0",
               instr_ready_output, issue_valid_output, write_reserve_output);
    end

    // Directed: clean issue, RAW stall, WAW stall, zero register.
    send(4'd1, 4'd2, 4'd3, 4'd4, 1'b1, 3);
    send(4'd3, 4'd5, 4'd6, 4'd2, 1'b1, -1);
    send(4'd4, 4'd2, 4'd0, 4'd7, 1'b1, -1);
    send(4'd5, 4'd1, 4'd1, 4'd7, 1'b1, -1);
    drain();
    send(4'd6, 4'd0, 4'd3, 4'd0, 1'b1, 2);
    send(4'd7, 4'd2, 4'd4, 4'd8, 1'b0, 2);
    send(4'd8, 4'd4, 4'd4, 4'd6, 1'b1, -1);
    send(4'd9, 4'd6, 4'd1, 4'd4, 1'b1, -1);
    drain();

    // Reset while holding an instruction in ISSUE.
    ready_mode = 2;
    for (int i = 0; i < REGISTER_SIZE; i++) arch_save[i] = arch[i];
    send(4'd10, 4'd2, 4'd3, 4'd4, 1'b1, -1);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (issue_valid_output) begin
        seen = 1;
        break;
      end
    end
    nchk++;
    if (!seen) begin
      nerr++;
      $display("FAIL reset_setup: issue_valid=0 after 20 cycles, need 1");
    end
    #2 rst = 1'b1;
    #1;
    nchk++;
    if (issue_valid_output !== 1'b0 || write_reserve_output !== 1'b0 || instr_ready_output !== 1'b1) begin
      nerr++;
      $display("FAIL reset_async: issue_valid=%b reserve=%b ready=%b, need 0/0/1",
               issue_valid_output, write_reserve_output, instr_ready_output);
    end
    if (sb.size() > 0) void'(sb.pop_back());
    for (int i = 0; i < REGISTER_SIZE; i++) arch[i] = arch_save[i];
    @(posedge clk); @(posedge clk);
    #3 rst = 1'b0;
    ready_mode = 0;
    @(negedge clk);
    nchk++;
    if (instr_ready_output !== 1'b1 || resv[4] !== 1'b0) begin
      nerr++;
      $display("FAIL reset_release: ready=%b reg4_reserved=%b, need 1/0", instr_ready_output, resv[4]);
    end

    // Randomized stream with small register range to provoke hazards.
    ready_mode = 1;
    wb_delay_rand = 1;
    for (int n = 0; n < 150; n++) begin
      send(4'($urandom), 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
           4'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0), -1);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
